// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit BCD to 7-segment scan driver with a frame-aligned
// shadow/display register pair, leading-zero blanking and per-digit decimal point.
module bcd_7seg_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  lzb_en,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_start
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = 4 * N_DIGITS;

    localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       sh_bcd_q, sh_bcd_d;
    logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [BW-1:0]       disp_bcd_q, disp_bcd_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                wrap_q, wrap_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_start_q, frame_start_d;

    logic                tick;
    logic                last_digit;
    logic                frame_end;
    logic [3:0]          cur_digit;
    logic                cur_dp;
    logic                blank;
    logic [N_DIGITS-1:0] an_raw;

    // Active-high segment pattern {a,b,c,d,e,f,g}; invalid codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    always_comb begin
        tick       = (presc_q == PW'(CLK_DIV - 1));
        last_digit = (idx_q == IW'(N_DIGITS - 1));
        frame_end  = tick && last_digit;

        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + IW'(1);
        end

        sh_bcd_d = load ? bcd_in : sh_bcd_q;
        sh_dp_d  = load ? dp_in  : sh_dp_q;

        // Refreshing from the already-updated shadow gives the same-cycle load bypass.
        disp_bcd_d = frame_end ? sh_bcd_d : disp_bcd_q;
        disp_dp_d  = frame_end ? sh_dp_d  : disp_dp_q;

        wrap_d        = frame_end;
        frame_start_d = wrap_q;

        cur_digit = '0;
        cur_dp    = 1'b0;
        blank     = 1'b0;
        an_raw    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = disp_bcd_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                an_raw[i] = 1'b1;
                blank     = lzb_en && (i != 0);
                for (int j = i; j < N_DIGITS; j++) begin
                    if (disp_bcd_q[4*j +: 4] != 4'd0) begin
                        blank = 1'b0;
                    end
                end
            end
        end

        seg_d = (blank ? 7'b0000000 : bcd_to_seg(cur_digit)) ^ SEG_OFF;
        dp_d  = cur_dp ^ DP_OFF;
        an_d  = an_raw ^ AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            sh_bcd_q      <= '0;
            sh_dp_q       <= '0;
            disp_bcd_q    <= '0;
            disp_dp_q     <= '0;
            wrap_q        <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            sh_bcd_q      <= sh_bcd_d;
            sh_dp_q       <= sh_dp_d;
            disp_bcd_q    <= disp_bcd_d;
            disp_dp_q     <= disp_dp_d;
            wrap_q        <= wrap_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign an_out      = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: fixed vectors, hand sequences for frame/reset
// corners, and a randomized run checked every cycle against a behavioural model.
module tb_bcd_7seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        lzb_en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b;
    logic [0:0] an_c;
    logic       fs_a, fs_b, fs_c;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    bcd_7seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load), .lzb_en(lzb_en),
        .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a), .frame_start(fs_a));

    bcd_7seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load), .lzb_en(lzb_en),
        .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b), .frame_start(fs_b));

    bcd_7seg_scan_driver #(.N_DIGITS(1), .CLK_DIV(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bcd_in(bcd_in[3:0]), .dp_in(dp_in[0:0]), .load(load), .lzb_en(lzb_en),
        .seg_out(seg_c), .dp_out(dp_c), .an_out(an_c), .frame_start(fs_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digit position derived from cycles elapsed since reset,
    // glyphs built from segment letter lists. Index 0 = 4 digits/div 4, 1 = 1 digit/div 2.
    string glyph_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "g", "g", "g", "g", "g", "g"};
    int         m_cyc   [2];
    int         m_sh    [2][4];
    bit         m_shdp  [2][4];
    int         m_dis   [2][4];
    bit         m_disdp [2][4];
    bit         m_fsn   [2];
    logic [6:0] e_seg   [2];
    logic       e_dp    [2];
    logic [3:0] e_an    [2];
    logic       e_fs    [2];

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] r;
        string s;
        r = '0;
        s = glyph_tbl[d];
        for (int i = 0; i < s.len(); i++) r[6 - (int'(s.getc(i)) - 97)] = 1'b1;
        return r;
    endfunction

    task automatic model_reset(input int k);
        m_cyc[k] = 0;
        m_fsn[k] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            m_sh[k][j] = 0; m_shdp[k][j] = 1'b0; m_dis[k][j] = 0; m_disdp[k][j] = 1'b0;
        end
        e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_an[k] = 4'hF; e_fs[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input int n, input int div);
        int idx;
        bit bnd, blank;
        idx   = (m_cyc[k] / div) % n;
        bnd   = ((m_cyc[k] % div) == div - 1) && (idx == n - 1);
        blank = lzb_en && (idx > 0);
        for (int j = idx; j < n; j++) if (m_dis[k][j] != 0) blank = 1'b0;
        e_seg[k] = blank ? 7'h7F : ~glyph(m_dis[k][idx]);
        e_dp[k]  = ~m_disdp[k][idx];
        e_an[k]  = 4'hF;
        e_an[k][idx] = 1'b0;
        e_fs[k]  = m_fsn[k];
        m_fsn[k] = bnd;
        if (load) for (int j = 0; j < n; j++) begin
            m_sh[k][j]   = int'(bcd_in[4*j +: 4]);
            m_shdp[k][j] = dp_in[j];
        end
        if (bnd) for (int j = 0; j < n; j++) begin
            m_dis[k][j]   = m_sh[k][j];
            m_disdp[k][j] = m_shdp[k][j];
        end
        m_cyc[k]++;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 4, 4);
            model_step(1, 1, 2);
        end
    end

    logic [6:0] inv_seg;
    logic [3:0] inv_an;
    logic       inv_dp;

    always @(negedge clk) begin
        if (mon_en) begin
            inv_seg = ~e_seg[0];
            inv_an  = ~e_an[0];
            inv_dp  = ~e_dp[0];
            chk("model_a_seg", seg_a, e_seg[0]);
            chk("model_a_dp",  dp_a,  e_dp[0]);
            chk("model_a_an",  an_a,  e_an[0]);
            chk("model_a_fs",  fs_a,  e_fs[0]);
            chk("model_b_seg", seg_b, inv_seg);
            chk("model_b_dp",  dp_b,  inv_dp);
            chk("model_b_an",  an_b,  inv_an);
            chk("model_b_fs",  fs_b,  e_fs[0]);
            chk("model_c_seg", seg_c, e_seg[1]);
            chk("model_c_dp",  dp_c,  e_dp[1]);
            chk("model_c_an",  an_c,  e_an[1][0]);
            chk("model_c_fs",  fs_c,  e_fs[1]);
        end
    end

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (fs_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fs_timeout: got no frame_start within 64 cycles, required a pulse");
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        @(negedge clk);
        bcd_in = b; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Expected seg fields are {digit3, digit2, digit1, digit0}, active-low.
    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
        logic [27:0] seg;
        logic [3:0]  dpo;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bit ok;
        logic [3:0] exp_an;

        vecs[0] = '{16'h0000, 4'b0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
        vecs[1] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h1234, 4'b0000, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
        vecs[3] = '{16'h0007, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}, 4'b1111};
        vecs[4] = '{16'h0007, 4'b0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}, 4'b1111};
        vecs[5] = '{16'h00A5, 4'b0010, 1'b0, {7'b0000001, 7'b0000001, 7'b1111110, 7'b0100100}, 4'b1101};
        vecs[6] = '{16'h00A5, 4'b0010, 1'b1, {7'b1111111, 7'b1111111, 7'b1111110, 7'b0100100}, 4'b1101};
        vecs[7] = '{16'h9999, 4'b0101, 1'b0, {7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}, 4'b1010};
        vecs[8] = '{16'h0100, 4'b1000, 1'b1, {7'b1111111, 7'b1001111, 7'b0000001, 7'b0000001}, 4'b0111};
        vecs[9] = '{16'h8F60, 4'b0000, 1'b1, {7'b0000000, 7'b1111110, 7'b0100000, 7'b0000001}, 4'b1111};

        reset = 1'b1; load = 1'b0; lzb_en = 1'b0; bcd_in = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg_a, 7'h7F);
        chk("rst_dp", dp_a, 1'b1);
        chk("rst_an", an_a, 4'hF);
        chk("rst_fs", fs_a, 1'b0);
        chk("rst_seg_hi", seg_b, 7'h00);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Idle scan: each digit held 4 cycles, frame_start every 16.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((c / 4) % 4));
            chk("idle_an", an_a, exp_an);
            chk("idle_seg", seg_a, 7'b0000001);
            chk("idle_fs", fs_a, (c % 16 == 0) && (c > 0));
        end

        // Mid-frame load: the current frame keeps showing the old zeros.
        do_load(16'h1234, 4'b0000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fs_a) begin
                ok = 1'b1;
                break;
            end
            chk("midframe_old", seg_a, 7'b0000001);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL midframe_fs: got no frame_start within 20 cycles, required a pulse");
        end
        chk("midframe_d0", seg_a, 7'b1001100);
        repeat (12) @(negedge clk);
        chk("midframe_d3", seg_a, 7'b1001111);

        foreach (vecs[v]) begin
            lzb_en = vecs[v].lzb;
            do_load(vecs[v].bcd, vecs[v].dp);
            wait_fs(ok);
            for (int d = 0; d < 4; d++) begin
                if (d > 0) repeat (4) @(negedge clk);
                exp_an = ~(4'b0001 << d);
                chk($sformatf("vec%0d_seg_d%0d", v, d), seg_a, vecs[v].seg[7*d +: 7]);
                chk($sformatf("vec%0d_dp_d%0d", v, d), dp_a, vecs[v].dpo[d]);
                chk($sformatf("vec%0d_an_d%0d", v, d), an_a, exp_an);
            end
        end

        // Load exactly on the frame-boundary tick goes straight to the display.
        wait_fs(ok);
        repeat (14) @(negedge clk);
        bcd_in = 16'h9999; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("bypass_fs", fs_a, 1'b1);
        chk("bypass_d0", seg_a, 7'b0000100);
        repeat (12) @(negedge clk);
        chk("bypass_d3", seg_a, 7'b0000100);
        wait_fs(ok);
        chk("bypass_shadow", seg_a, 7'b0000100);

        // Reset during digit 2 clears everything and restarts the scan.
        lzb_en = 1'b0;
        wait_fs(ok);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_an", an_a, 4'hF);
        chk("midrst_seg", seg_a, 7'h7F);
        chk("midrst_dp", dp_a, 1'b1);
        chk("midrst_fs", fs_a, 1'b0);
        chk("midrst_seg_hi", seg_b, 7'h00);
        chk("midrst_an_hi", an_b, 4'h0);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_an = (c < 4) ? 4'b1110 : 4'b1101;
            chk("restart_an", an_a, exp_an);
            chk("restart_seg", seg_a, 7'b0000001);
        end
        wait_fs(ok);
        chk("restart_shadow", seg_a, 7'b0000001);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            load  = ($urandom % 5) == 0;
            reset = ($urandom % 150) == 0;
            for (int j = 0; j < 4; j++)
                bcd_in[4*j +: 4] = (($urandom % 3) == 0) ? 4'd0 : 4'($urandom % 16);
            dp_in = 4'($urandom % 16);
            if (($urandom % 20) == 0) lzb_en = ~lzb_en;
        end
        @(negedge clk);
        load = 1'b0; reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_scan_driver.md
Name: bcd_7seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Takes a packed multi-digit BCD word, latches it into a shadow register and swaps it into the display register only at frame boundaries, so digits never tear.
- Scans one digit at a time at a programmable rate, decodes BCD to segments, and applies leading-zero blanking and a per-digit decimal point.
- Generalises the team's single-digit combinational BCD-to-7-segment decoder; sits between the counter/score logic and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1–8.
- CLK_DIV, 50000, clock cycles each digit is held; legal range ≥2.
- SEG_ACTIVE_LOW, 1, 1 means a segment is lit when its bit is 0 (matches the existing decoder's polarity).
- AN_ACTIVE_LOW, 1, 1 means a digit enable is active when its bit is 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bcd_in  in  4*N_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is the rightmost/least significant.
- dp_in  in  N_DIGITS  decimal point request per digit.
- load  in  1  one-cycle strobe; captures bcd_in/dp_in into the shadow register.
- lzb_en  in  1  leading-zero blanking enable.
- seg_out  out  7  segments {a,b,c,d,e,f,g} = seg_out[6:0].
- dp_out  out  1  decimal point for the active digit.
- an_out  out  N_DIGITS  one-hot digit enable.
- frame_start  out  1  one-cycle pulse when the display register is refreshed (index wraps to 0).

Behaviour:
- Reset (synchronous, checked every edge, overrides everything, including mid-frame):
  - prescaler = 0, digit index = 0.
  - shadow and display registers = 0.
  - seg_out and dp_out all unlit.
  - an_out all inactive.
  - frame_start = 0.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick = (prescaler == CLK_DIV-1).
- Digit index:
  - On tick, index advances; N_DIGITS-1 wraps to 0.
  - With N_DIGITS = 1, the index stays 0 and every tick is a frame boundary.
- load: on a load cycle, shadow <= {bcd_in, dp_in}. Repeated loads within a frame simply overwrite; the last one wins.
- Frame boundary (tick while index == N_DIGITS-1):
  - display <= shadow.
  - If load is asserted in the same cycle, display <= bcd_in/dp_in directly (bypass); the shadow is also updated.
  - frame_start = 1 on the following cycle, aligned with the first cycle digit 0 is driven.
- Outputs are registered from index/display, so they change 1 cycle after the index changes. Each digit is therefore driven for exactly CLK_DIV consecutive cycles.
  - The first digit-0 drive after reset starts at cycle 1 after reset deasserts.
- Decode, lit segments:
  - 0: abcdef
  - 1: bc
  - 2: abdeg
  - 3: abcdg
  - 4: bcfg
  - 5: acdfg
  - 6: acdefg
  - 7: abc
  - 8: abcdefg
  - 9: abcdfg
  - 10–15 (invalid): g only (dash).
  - Polarity is applied after decode, per SEG_ACTIVE_LOW.
- Leading-zero blanking: with lzb_en = 1, digit i (i ≥ 1) is blanked when display digits i..N_DIGITS-1 are all 0.
  - Blanked means all segments unlit; its an_out bit is still asserted.
  - Digit 0 is never blanked, so the value 0 shows "0".
  - dp_out is not affected by blanking.
  - lzb_en is sampled live; there is no frame alignment.
- an_out: exactly one bit active when out of reset; bit = index. Polarity per AN_ACTIVE_LOW.
- Counter width: $clog2(CLK_DIV). No overflow is possible because wrap is explicit.

Test Plan (N_DIGITS=4, CLK_DIV=4, both polarities active-low unless noted):
- Reset then idle 40 cycles:
  - seg_out=7'b0000001 (digit 0 shows "0"), digits 1–3 blanked only if lzb_en=1.
  - an_out cycles 1110→1101→1011→0111, each held exactly 4 cycles.
  - frame_start pulses every 16 cycles.
- load bcd_in=16'h1234 mid-frame:
  - Current frame still shows 0000.
  - From the next frame_start, digit 0 = "4" (seg_out=7'b1001100), digit 3 = "1" (7'b1001111).
- load 16'h0007 with lzb_en=1:
  - Digits 3, 2, 1 show seg_out=7'b1111111 with an_out still active.
  - Digit 0 shows "7" (7'b0001111).
  - With lzb_en=0, the zeros are displayed.
- load 16'h00A5, dp_in=4'b0010:
  - Digit 1 shows dash (7'b1111110) with dp_out=0 (lit).
  - Other digits have dp_out=1.
- load asserted exactly on the frame-boundary tick with 16'h9999:
  - Next frame shows 9999 (bypass, no one-frame delay).
- Assert reset mid-digit-2:
  - Next cycle all outputs inactive (an_out=1111, seg_out=1111111).
  - Display and shadow cleared.
  - Scan restarts at digit 0.
  - Repeat with SEG_ACTIVE_LOW=0 and check that segment values are inverted.
